// File: rtl/sap_if.sv
// sap_if: control/program-load inputs and status outputs of the SAP-1 datapath
interface sap_if #(parameter int WIDTH = 8, parameter int ADDR_W = 4) ();
    logic [15:0]       ctrl;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [WIDTH-1:0]  prog_data;
    logic [3:0]        instruction;
    logic [WIDTH-1:0]  out_reg;
    logic [WIDTH-1:0]  bus;
    logic              carry;
    logic              zero;
    logic              bus_conflict;
    modport master (
        output ctrl, prog_we, prog_addr, prog_data,
        input  instruction, out_reg, bus, carry, zero, bus_conflict
    );
    modport slave (
        input  ctrl, prog_we, prog_addr, prog_data,
        output instruction, out_reg, bus, carry, zero, bus_conflict
    );
endinterface

// File: rtl/sap_datapath.sv
// sap_datapath: SAP-1 execution datapath driven by the microcode control word
module sap_datapath #(parameter int WIDTH = 8, parameter int ADDR_W = 4) (
    input logic  clk,
    input logic  reset_n,
    sap_if.slave sap
);
    logic hlt, mi, ri, ro, io_en, ii, ai, ao, smo, su, bi, oi, ce, co, je;
    logic [ADDR_W-1:0] pc, mar;
    logic [WIDTH-1:0]  ir, a, b, out_q, bus, alu;
    logic [WIDTH:0]    sum;
    logic              carry_q, zero_q;
    logic [WIDTH-1:0]  ram [2**ADDR_W];

    assign {hlt, mi, ri, ro, io_en, ii, ai, ao, smo, su, bi, oi, ce, co, je} = sap.ctrl[15:1];

    // Subtraction is A + ~B + 1, so carry=1 means no borrow
    assign sum = {1'b0, a} + {1'b0, su ? ~b : b} + {{WIDTH{1'b0}}, su};
    assign alu = sum[WIDTH-1:0];

    // Bus driver with fixed priority RO > AO > SMO > IO > CO; idle bus reads 0
    always_comb begin
        bus = ro    ? ram[mar] :
              ao    ? a :
              smo   ? alu :
              io_en ? {{(WIDTH-4){1'b0}}, ir[3:0]} :
              co    ? {{(WIDTH-ADDR_W){1'b0}}, pc} : '0;
    end

    assign sap.bus          = bus;
    assign sap.bus_conflict = $countones({ro, ao, smo, io_en, co}) > 1;
    assign sap.instruction  = ir[7:4];
    assign sap.out_reg      = out_q;
    assign sap.carry        = carry_q;
    assign sap.zero         = zero_q;

    // Architectural registers; every load takes the bus value of the current cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc      <= '0;
            mar     <= '0;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            out_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else if (!hlt) begin
            if (mi) mar <= bus[ADDR_W-1:0];
            if (ii) ir <= bus;
            if (ai) a <= bus;
            if (bi) b <= bus;
            if (oi) out_q <= bus;
            if (je) pc <= bus[ADDR_W-1:0];
            else if (ce) pc <= pc + 1'b1;
            if (smo && ai) begin
                carry_q <= sum[WIDTH];
                zero_q  <= (alu == '0);
            end
        end
    end

    // RAM keeps its contents through reset; writes are suppressed while reset is asserted
    always_ff @(posedge clk or negedge reset_n) begin
        if (reset_n) begin
            if (hlt && sap.prog_we) ram[sap.prog_addr] <= sap.prog_data;
            else if (!hlt && ri) ram[mar] <= bus;
        end
    end
endmodule
